riscv_decode_stage: RTL and testbench

- Single-issue RV32I decode pipeline stage between fetch and execute.
- Turns a raw 32-bit instruction plus its PC into the control and operand fields the execute ALU consumes: i_en, b_en, funct3, funct7, register indices and a sign-extended immediate.
- Valid/ready on both sides, one-cycle latency, two-entry skid buffer so in_ready is a pure register output.
- Flush input discards in-flight instructions after a taken branch or jump.

---
 rtl/riscv_decode_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: raw instruction + PC in, ALU control/operand fields out.
// Ports: clk/rst_n/flush, in_* valid/ready from fetch, out_* valid/ready to execute.
module riscv_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_op_class,
  output logic            out_jalr,
  output logic            out_i_en,
  output logic            out_b_en,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      op_class;
    logic            jalr;
    logic            i_en;
    logic            b_en;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  dec_t            dec;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25],
                  in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31],
                  in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    unique case (1'b1)
      opc == OPC_OP: begin
        dec.op_class = 3'd0;
        dec.funct3   = f3;
        dec.funct7   = f7;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
        dec.illegal  = !(f7 == 7'h00 || f7 == 7'h20) ||
                       (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5));
      end
      opc == OPC_OPIMM: begin
        dec.op_class = 3'd1;
        dec.i_en     = 1'b1;
        dec.funct3   = f3;
        dec.funct7   = f7;
        dec.rs1      = rs1;
        dec.rd       = rd;
        dec.imm      = imm_i;
        dec.illegal  = (f3 == 3'd1 && f7 != 7'h00) ||
                       (f3 == 3'd5 &&
                        !(f7 == 7'h00 || f7 == 7'h20));
      end
      opc == OPC_BRANCH: begin
        dec.op_class = 3'd2;
        dec.b_en     = 1'b1;
        dec.funct3   = f3;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.imm      = imm_b;
        dec.illegal  = (f3 == 3'd2 || f3 == 3'd3);
      end
      opc == OPC_LOAD: begin
        dec.op_class = 3'd3;
        dec.funct3   = f3;
        dec.rs1      = rs1;
        dec.rd       = rd;
        dec.imm      = imm_i;
        dec.illegal  = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      opc == OPC_STORE: begin
        dec.op_class = 3'd4;
        dec.funct3   = f3;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.imm      = imm_s;
        dec.illegal  = (f3 > 3'd2);
      end
      opc == OPC_LUI: begin
        dec.op_class = 3'd5;
        dec.rd       = rd;
        dec.imm      = imm_u;
      end
      opc == OPC_AUIPC: begin
        dec.op_class = 3'd6;
        dec.rd       = rd;
        dec.imm      = imm_u;
      end
      opc == OPC_JAL: begin
        dec.op_class = 3'd7;
        dec.b_en     = 1'b1;
        dec.rd       = rd;
        dec.imm      = imm_j;
      end
      opc == OPC_JALR: begin
        dec.op_class = 3'd7;
        dec.jalr     = 1'b1;
        dec.funct3   = f3;
        dec.rs1      = rs1;
        dec.rd       = rd;
        dec.imm      = imm_i;
        dec.illegal  = (f3 != 3'd0);
      end
      default: begin
        // Unknown opcode (includes instr[1:0] != 11):
        // raw register fields pass through, flagged illegal.
        dec.funct3  = f3;
        dec.rs1     = rs1;
        dec.rs2     = rs2;
        dec.rd      = rd;
        dec.illegal = 1'b1;
      end
    endcase
  end

  dec_t out_q;
  dec_t skid_q;
  logic skid_valid;
  logic in_xfer;
  logic out_free;

  assign in_xfer  = in_valid && in_ready;
  // Output register may load this cycle: empty or draining.
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        // in_ready is low while the skid is full, so
        // no input can arrive on this path.
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else begin
        if (in_xfer) begin
          out_q <= dec;
        end
        out_valid <= in_xfer;
        in_ready  <= 1'b1;
      end
    end else if (in_xfer) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

  assign out_pc       = out_q.pc;
  assign out_op_class = out_q.op_class;
  assign out_jalr     = out_q.jalr;
  assign out_i_en     = out_q.i_en;
  assign out_b_en     = out_q.b_en;
  assign out_funct3   = out_q.funct3;
  assign out_funct7   = out_q.funct7;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_imm      = out_q.imm;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Testbench for riscv_decode_stage: fixed vectors, hand sequences,
// and random traffic against a queue-based reference model.
module tb_riscv_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [2:0]  out_op_class;
  logic        out_jalr;
  logic        out_i_en;
  logic        out_b_en;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_illegal;

  always #5 clk = ~clk;

  riscv_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op_class(out_op_class),
    .out_jalr(out_jalr), .out_i_en(out_i_en),
    .out_b_en(out_b_en), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  typedef struct {
    logic        known;
    logic [31:0] pc;
    logic [2:0]  cls;
    logic        jalr;
    logic        i_en;
    logic        b_en;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    exp_t        e;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference decoder built from the ISA field rules.
  function automatic exp_t model(logic [31:0] ins,
                                 logic [31:0] pc);
    exp_t e;
    int opc = int'(ins & 32'h7F);
    int f3  = int'((ins >> 12) & 7);
    int f7  = int'((ins >> 25) & 127);
    int s   = $signed(ins);
    int ii  = s >>> 20;
    int is  = ((s >>> 25) << 5) | int'((ins >> 7) & 31);
    int ib  = ((s >>> 31) << 12) | int'(((ins >> 7) & 1) << 11)
            | int'(((ins >> 25) & 63) << 5)
            | int'(((ins >> 8) & 15) << 1);
    int iu  = int'(ins & 32'hFFFFF000);
    int ij  = ((s >>> 31) << 20) | int'(((ins >> 12) & 255) << 12)
            | int'(((ins >> 20) & 1) << 11)
            | int'(((ins >> 21) & 1023) << 1);
    logic [4:0] r1 = 5'((ins >> 15) & 31);
    logic [4:0] r2 = 5'((ins >> 20) & 31);
    logic [4:0] rd = 5'((ins >> 7) & 31);
    e = '{default: '0};
    e.pc = pc;
    e.known = 1'b1;
    case (opc)
      'h33: begin
        e.f3 = 3'(f3); e.f7 = 7'(f7);
        e.rs1 = r1; e.rs2 = r2; e.rd = rd;
        e.ill = !(f7 == 0 || f7 == 32) ||
                (f7 == 32 && f3 != 0 && f3 != 5);
      end
      'h13: begin
        e.cls = 1; e.i_en = 1;
        e.f3 = 3'(f3); e.f7 = 7'(f7);
        e.rs1 = r1; e.rd = rd; e.imm = ii;
        e.ill = (f3 == 1 && f7 != 0) ||
                (f3 == 5 && f7 != 0 && f7 != 32);
      end
      'h63: begin
        e.cls = 2; e.b_en = 1; e.f3 = 3'(f3);
        e.rs1 = r1; e.rs2 = r2; e.imm = ib;
        e.ill = (f3 == 2 || f3 == 3);
      end
      'h03: begin
        e.cls = 3; e.f3 = 3'(f3);
        e.rs1 = r1; e.rd = rd; e.imm = ii;
        e.ill = (f3 == 3 || f3 >= 6);
      end
      'h23: begin
        e.cls = 4; e.f3 = 3'(f3);
        e.rs1 = r1; e.rs2 = r2; e.imm = is;
        e.ill = (f3 > 2);
      end
      'h37: begin e.cls = 5; e.rd = rd; e.imm = iu; end
      'h17: begin e.cls = 6; e.rd = rd; e.imm = iu; end
      'h6F: begin
        e.cls = 7; e.b_en = 1; e.rd = rd; e.imm = ij;
      end
      'h67: begin
        e.cls = 7; e.jalr = 1; e.f3 = 3'(f3);
        e.rs1 = r1; e.rd = rd; e.imm = ii;
        e.ill = (f3 != 0);
      end
      default: begin e.known = 0; e.ill = 1; end
    endcase
    return e;
  endfunction

  task automatic cmp_out(exp_t e, string t);
    chk({t, "_pc"}, out_pc, e.pc);
    chk({t, "_illegal"}, 32'(out_illegal), 32'(e.ill));
    if (e.known) begin
      chk({t, "_class"}, 32'(out_op_class), 32'(e.cls));
      chk({t, "_jalr"}, 32'(out_jalr), 32'(e.jalr));
      chk({t, "_i_en"}, 32'(out_i_en), 32'(e.i_en));
      chk({t, "_b_en"}, 32'(out_b_en), 32'(e.b_en));
      chk({t, "_funct3"}, 32'(out_funct3), 32'(e.f3));
      chk({t, "_funct7"}, 32'(out_funct7), 32'(e.f7));
      chk({t, "_rs1"}, 32'(out_rs1), 32'(e.rs1));
      chk({t, "_rs2"}, 32'(out_rs2), 32'(e.rs2));
      chk({t, "_rd"}, 32'(out_rd), 32'(e.rd));
      chk({t, "_imm"}, out_imm, e.imm);
    end
  endtask

  task automatic zero_chk(string t);
    chk({t, "_valid"}, 32'(out_valid), 0);
    chk({t, "_in_ready"}, 32'(in_ready), 1);
    chk({t, "_fields"},
        32'(|{out_pc, out_op_class, out_jalr, out_i_en,
              out_b_en, out_funct3, out_funct7, out_rs1,
              out_rs2, out_rd, out_imm, out_illegal}), 0);
  endtask

  // One clock: drive at negedge, score transfers, advance model.
  task automatic cyc(logic v, logic [31:0] ins, logic [31:0] pc,
                     logic ordy, logic fl, logic rst);
    logic ix;
    logic ox;
    exp_t e;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rst;
    #1;
    ix = v && in_ready;
    ox = out_valid && out_ready;
    if (rst && ox) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        cmp_out(e, "out");
      end
    end
    @(posedge clk);
    #1;
    if (!rst || fl) q.delete();
    else if (ix) q.push_back(model(ins, pc));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    @(negedge clk);
  endtask

  function automatic exp_t mk(logic [2:0] cls, logic jalr,
      logic i_en, logic b_en, logic [2:0] f3, logic [6:0] f7,
      logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
      logic [31:0] imm, logic ill, logic known);
    exp_t e;
    e = '{known, 32'h0, cls, jalr, i_en, b_en, f3, f7,
          rs1, rs2, rd, imm, ill};
    return e;
  endfunction

  logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23,
                           7'h37, 7'h17, 7'h6F, 7'h67};

  initial begin
    vec_t        vt[$];
    exp_t        e;
    logic [31:0] ins;
    in_valid = 0; in_instr = 0; in_pc = 0;
    out_ready = 1; flush = 0; rst_n = 0;
    @(negedge clk);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    zero_chk("reset");

    vt.push_back('{32'h002081B3,
      mk(0, 0, 0, 0, 0, 7'h00, 1, 2, 3, 32'h0, 0, 1)});
    vt.push_back('{32'hFFF00293,
      mk(1, 0, 1, 0, 0, 7'h7F, 0, 0, 5, 32'hFFFFFFFF, 0, 1)});
    vt.push_back('{32'h40F0D093,
      mk(1, 0, 1, 0, 5, 7'h20, 1, 0, 1, 32'h40F, 0, 1)});
    vt.push_back('{32'hFE208EE3,
      mk(2, 0, 0, 1, 0, 7'h00, 1, 2, 0, 32'hFFFFFFFC, 0, 1)});
    vt.push_back('{32'h0000007F,
      mk(0, 0, 0, 0, 0, 7'h00, 0, 0, 0, 32'h0, 1, 0)});
    vt.push_back('{32'h02208133,
      mk(0, 0, 0, 0, 0, 7'h01, 1, 2, 2, 32'h0, 1, 1)});
    vt.push_back('{32'h123452B7,
      mk(5, 0, 0, 0, 0, 7'h00, 0, 0, 5, 32'h12345000, 0, 1)});
    vt.push_back('{32'h0020A423,
      mk(4, 0, 0, 0, 2, 7'h00, 1, 2, 0, 32'h8, 0, 1)});
    vt.push_back('{32'h000080E7,
      mk(7, 1, 0, 0, 0, 7'h00, 1, 0, 1, 32'h0, 0, 1)});

    foreach (vt[i]) begin
      e    = vt[i].e;
      e.pc = 32'h100 + 32'(i * 4);
      cyc(1, vt[i].ins, e.pc, 1, 0, 1);
      chk("vec_valid", 32'(out_valid), 1);
      cmp_out(e, $sformatf("vec%0d", i));
    end
    cyc(0, 0, 0, 1, 0, 1);

    // Back-pressure: A held, B in skid, then both drain in order.
    cyc(1, 32'h00100093, 32'h200, 0, 0, 1);
    cyc(1, 32'h00200113, 32'h204, 0, 0, 1);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    cyc(1, 32'h00300193, 32'h208, 0, 0, 1);
    chk("bp_hold_pc", out_pc, 32'h200);
    cyc(0, 0, 0, 1, 0, 1);
    chk("bp_b_pc", out_pc, 32'h204);
    cyc(0, 0, 0, 1, 0, 1);
    chk("bp_drained", 32'(out_valid), 0);

    // Flush with both entries full and a new input offered.
    cyc(1, 32'h00100093, 32'h300, 0, 0, 1);
    cyc(1, 32'h00200113, 32'h304, 0, 0, 1);
    cyc(1, 32'h00300193, 32'h308, 0, 1, 1);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_in_ready", 32'(in_ready), 1);
    cyc(1, 32'h00400213, 32'h30C, 1, 0, 1);
    chk("fl_next_pc", out_pc, 32'h30C);
    cyc(0, 0, 0, 1, 0, 1);
    chk("fl_alone", 32'(out_valid), 0);

    // Reset mid-stream with the skid full.
    cyc(1, 32'h00100093, 32'h400, 0, 0, 1);
    cyc(1, 32'h00200113, 32'h404, 0, 0, 1);
    cyc(1, 32'h00300193, 32'h408, 0, 0, 0);
    zero_chk("mid_reset");

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ins = $urandom;
      end else begin
        ins = ($urandom & 32'hFFFFFF80) |
              32'(opcs[$urandom_range(0, 8)]);
        case ($urandom_range(0, 3))
          0: ins[31:25] = 7'h00;
          1: ins[31:25] = 7'h20;
          default: ;
        endcase
      end
      cyc(1'($urandom_range(0, 3) != 0), ins, $urandom,
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 29) == 0), 1);
    end
    for (int n = 0; n < 4; n++) cyc(0, 0, 0, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
